serial_compadd: RTL and testbench

- Multi-cycle wide adder that consumes the sum/sum+1 pair produced by the team's compound adder, one W-bit chunk per clock.
- Latches two CHUNKS*W-bit operands on a start pulse, then walks chunks LSB-first.
- For each chunk, uses the registered carry from the previous chunk to pick the compound adder's s (carry 0) or t (carry 1) output.
- Lets a narrow compound adder serve wide datapaths, e.g. counters and coordinate arithmetic in the PS2/VGA path, at one chunk per cycle.

---
 rtl/serial_compadd.sv | 95 +++++++++
 tb/tb_serial_compadd.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_compadd.sv
// serial_compadd: chunk-serial wide adder built on a narrow compound adder
module Compadder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   s,
  output logic [W:0]   t
);
  assign s = {1'b0, a} + {1'b0, b};
  assign t = s + 1'b1;
endmodule

module serial_compadd #(
  parameter int W      = 4,
  parameter int CHUNKS = 4,
  localparam int TW    = W * CHUNKS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [TW-1:0] a_in,
  input  logic [TW-1:0] b_in,
  input  logic          cin,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] sum,
  output logic          cout
);
  localparam int IW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [TW-1:0] a_r, b_r, part, next_part;
  logic [IW-1:0] idx;
  logic carry;
  logic [W-1:0] ca, cb;
  logic [W:0] s, t, res;
  Compadder #(.W(W)) u_cadd (.a(ca), .b(cb), .s(s), .t(t));
  // select current chunk, pick s/t by incoming carry, splice result into partial sum
  always_comb begin
    ca = a_r[idx*W +: W];
    cb = b_r[idx*W +: W];
    res = carry ? t : s;
    next_part = part;
    next_part[idx*W +: W] = res[W-1:0];
  end
  // control FSM with registered busy/done and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      part <= '0;
      sum <= '0;
      cout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r <= a_in;
            b_r <= b_in;
            carry <= cin;
            idx <= '0;
            busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          part <= next_part;
          carry <= res[W];
          if (idx == LAST) begin
            sum <= next_part;
            cout <= res[W];
            done <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_compadd.sv
// tb_serial_compadd: directed and random checks of the chunk-serial adder
module tb_serial_compadd;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic cin = 1'b0;
  logic busy, done, cout;
  logic [15:0] sum;
  logic start1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0;
  logic cin1 = 1'b0;
  logic busy1, done1, cout1;
  logic [3:0] sum1;
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  serial_compadd dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_compadd #(.W(4), .CHUNKS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  // called at a negedge; returns at a negedge with the DUT back in IDLE
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output int lat, output int busy_n);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int n = 1; n <= 20; n++) begin
      if (busy) busy_n++;
      if (done && lat == 0) lat = n;
      if (lat != 0 && !busy) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({cout, sum} !== 17'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", {cout, sum}); end
    checks++; if ({busy1, done1, cout1, sum1} !== 8'h0) begin errors++; $display("FAIL reset_dut1 got=%h exp=0", {busy1, done1, cout1, sum1}); end
  endtask

  task automatic test_overflow;
    int lat, bn;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, bn);
    checks++; if ({cout, sum} !== 17'h10000) begin errors++; $display("FAIL ovf_sum got=%h exp=10000", {cout, sum}); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL ovf_latency got=%0d exp=5", lat); end
    checks++; if (bn !== 5) begin errors++; $display("FAIL ovf_busy_cycles got=%0d exp=5", bn); end
  endtask

  task automatic test_hold;
    int lat, bn, d0;
    run_op(16'h1234, 16'h4321, 1'b1, lat, bn);
    checks++; if ({cout, sum} !== 17'h05556) begin errors++; $display("FAIL hold_sum got=%h exp=05556", {cout, sum}); end
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin = 1'b1;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    checks++; if ({cout, sum} !== 17'h05556) begin errors++; $display("FAIL hold_keep got=%h exp=05556", {cout, sum}); end
    checks++; if (done_cnt - d0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL hold_idle got_dones=%0d busy=%b exp=0,0", done_cnt - d0, busy); end
  endtask

  task automatic test_back_to_back;
    int dc[4];
    int k = 0;
    a_in = 16'h0F0F; b_in = 16'h00F1; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        if (k < 4) dc[k] = n;
        k++;
        checks++; if ({cout, sum} !== 17'h01000) begin errors++; $display("FAIL b2b_sum got=%h exp=01000", {cout, sum}); end
      end
    end
    start = 1'b0;
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", k); end
    if (k == 3) begin
      checks++; if (dc[0] !== 5 || dc[1] !== 11 || dc[2] !== 17) begin errors++; $display("FAIL b2b_cycles got=%0d,%0d,%0d exp=5,11,17", dc[0], dc[1], dc[2]); end
    end
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int lat, bn;
    a_in = 16'hAAAA; b_in = 16'h5555; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_ctrl got=%b exp=00", {busy, done}); end
    checks++; if ({cout, sum} !== 17'h0) begin errors++; $display("FAIL midrst_sum got=%h exp=0", {cout, sum}); end
    run_op(16'hAAAA, 16'h5555, 1'b1, lat, bn);
    checks++; if ({cout, sum} !== 17'h10000 || lat !== 5) begin errors++; $display("FAIL midrst_rerun got=%h lat=%0d exp=10000 lat=5", {cout, sum}, lat); end
  endtask

  task automatic test_chunks1;
    int lat;
    logic [4:0] exp_r[2] = '{5'h10, 5'h0F};
    logic [3:0] av[2] = '{4'hF, 4'h7};
    logic [3:0] bv[2] = '{4'h0, 4'h8};
    logic cv[2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      a1 = av[i]; b1 = bv[i]; cin1 = cv[i]; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        if (done1 && lat == 0) lat = n;
        if (lat != 0 && !busy1) break;
        @(negedge clk);
      end
      checks++; if ({cout1, sum1} !== exp_r[i]) begin errors++; $display("FAIL c1_sum%0d got=%h exp=%h", i, {cout1, sum1}, exp_r[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL c1_latency%0d got=%0d exp=2", i, lat); end
    end
  endtask

  task automatic test_random;
    int lat, bn, d0;
    logic [15:0] a, b;
    logic c;
    logic [16:0] exp_r;
    d0 = done_cnt;
    for (int i = 0; i < 500; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      exp_r = {1'b0, a} + {1'b0, b} + {16'h0, c};
      run_op(a, b, c, lat, bn);
      checks++; if ({cout, sum} !== exp_r || lat !== 5) begin errors++; $display("FAIL rand%0d a=%h b=%h c=%b got=%h lat=%0d exp=%h lat=5", i, a, b, c, {cout, sum}, lat, exp_r); end
    end
    checks++; if (done_cnt - d0 !== 500) begin errors++; $display("FAIL rand_done_count got=%0d exp=500", done_cnt - d0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_overflow;
    test_hold;
    test_back_to_back;
    test_reset_mid_run;
    test_chunks1;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
